// File: rtl/lsu_pkg.sv
// Shared state type, func3 size codes and lane helpers for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Halfwords drop b[0]; any non-byte, non-half store code is a full word.
    function automatic logic [3:0] wstrb_for(input logic [2:0] func3, input logic [1:0] b);
        logic [3:0] strb;
        case (func3)
            F3_B:    strb = 4'b0001 << b;
            F3_H:    strb = b[1] ? 4'b1100 : 4'b0011;
            F3_W:    strb = 4'b1111;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic is_misaligned(input logic is_store, input logic [2:0] func3,
                                           input logic [1:0] b);
        logic half;
        logic word;
        if (is_store) begin
            half = (func3 == F3_H);
            word = !half && (func3 != F3_B);
        end else begin
            half = (func3 == F3_H) || (func3 == F3_HU);
            word = !half && (func3 != F3_B) && (func3 != F3_BU);
        end
        return (half && b[0]) || (word && (b != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory bus between the load/store unit (master) and memory (slave).
// Handshake: a request transfers on a clock edge where req_valid && req_ready; the master
// holds all req_* fields stable while req_valid is high and not yet accepted. Read data
// arrives later with rsp_valid (no back-pressure). rsp_err qualifies rsp_valid for reads
// and req_ready for writes.
interface lsu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_wstrb;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wstrb, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wstrb, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store strobe/data replication and load extract/extend.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  b,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        wstrb = wstrb_for(func3, b);
        case (func3)
            F3_B:    wdata = {4{store_data[7:0]}};
            F3_H:    wdata = {2{store_data[15:0]}};
            F3_W:    wdata = store_data;
            default: wdata = store_data;
        endcase

        byte_sel = rdata[{b, 3'b000} +: 8];
        half_sel = b[1] ? rdata[31:16] : rdata[15:0];
        case (func3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: issues one bus access per decoded load/store and stalls the core until it retires.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses instead of force-aligning them.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        func3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic [DATA_W-1:0] load_data,
    output logic              access_err,
    output logic [1:0]        state_dbg,
    lsu_if.master             bus
);
    lsu_state_e        state_q, state_d;
    logic [2:0]        f3_q;
    logic [1:0]        b_q;
    logic              we_q;
    logic              err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        wstrb_q;
    logic [DATA_W-1:0] wdata_q;

    logic              req_any;
    logic              trap;
    logic [2:0]        f3_sel;
    logic [1:0]        b_sel;
    logic [3:0]        lane_wstrb;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] load_fmt;

    assign req_any = mem_read | mem_write;

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = req_any & is_misaligned(mem_write, func3, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    // One aligner serves both directions: live decode in IDLE, latched access afterwards.
    assign f3_sel = (state_q == IDLE) ? func3 : f3_q;
    assign b_sel  = (state_q == IDLE) ? addr[1:0] : b_q;

    lsu_align u_align (
        .func3      (f3_sel),
        .b          (b_sel),
        .store_data (store_data),
        .rdata      (bus.rsp_rdata),
        .wstrb      (lane_wstrb),
        .wdata      (lane_wdata),
        .load_data  (load_fmt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (trap) state_d = DONE;
                      else if (req_any) state_d = REQ;
            REQ:      if (bus.req_ready) state_d = we_q ? DONE : WAIT_RSP;
            WAIT_RSP: if (bus.rsp_valid) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            f3_q      <= '0;
            b_q       <= '0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            wstrb_q   <= '0;
            wdata_q   <= '0;
            load_data <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (req_any) begin
                    f3_q    <= func3;
                    b_q     <= addr[1:0];
                    we_q    <= mem_write;
                    err_q   <= trap;
                    addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                    wstrb_q <= lane_wstrb;
                    wdata_q <= lane_wdata;
                end
                REQ: if (bus.req_ready && we_q) err_q <= bus.rsp_err;
                WAIT_RSP: if (bus.rsp_valid) begin
                    load_data <= load_fmt;
                    err_q     <= bus.rsp_err;
                end
                default: ;
            endcase
        end
    end

    // DONE is the retire cycle, so stall is low there even if the decoder still shows the access.
    always_comb begin
        stall = 1'b0;
        case (state_q)
            IDLE:          stall = req_any & rst_n;
            REQ, WAIT_RSP: stall = 1'b1;
            default:       stall = 1'b0;
        endcase
    end

    assign access_err    = (state_q == DONE) & err_q;
    assign state_dbg     = state_q;
    assign bus.req_valid = (state_q == REQ);
    assign bus.req_we    = we_q;
    assign bus.req_addr  = addr_q;
    assign bus.req_wstrb = wstrb_q;
    assign bus.req_wdata = wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: acts as the decoder and the memory, with a lane/extend model.
module tb_load_store_unit;
    import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] addr, store_data;
    logic        stall, access_err;
    logic [31:0] load_data;
    logic [1:0]  state_dbg;

    lsu_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .func3      (func3),
        .addr       (addr),
        .store_data (store_data),
        .stall      (stall),
        .load_data  (load_data),
        .access_err (access_err),
        .state_dbg  (state_dbg),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] model_ld   = '0;
    logic [31:0] exp_addr   = '0;
    logic [31:0] exp_wdata  = '0;
    logic [3:0]  exp_wstrb  = '0;
    logic        exp_we     = 1'b0;
    logic        txn_active = 1'b0;
    logic        no_req     = 1'b0;
    logic        done_flag  = 1'b0;
    logic        model_err  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] model_wstrb(input logic [2:0] f3, input logic [31:0] a);
        int b;
        b = int'(a[1:0]);
        if (f3 == 3'b000) return 4'(1 << b);
        if (f3 == 3'b001) return (b >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3 == 3'b000) return 32'(sd[7:0]) * 32'h0101_0101;
        if (f3 == 3'b001) return 32'(sd[15:0]) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int b, v;
        b = int'(a[1:0]);
        case (f3)
            3'b000, 3'b100: begin
                v = int'((rd >> (8 * b)) & 32'hFF);
                if (f3 == 3'b000 && v > 127) v -= 256;
            end
            3'b001, 3'b101: begin
                v = int'((rd >> ((b / 2) * 16)) & 32'hFFFF);
                if (f3 == 3'b001 && v > 32767) v -= 65536;
            end
            default: v = int'(rd);
        endcase
        return 32'(v);
    endfunction

    // Per-cycle compare against the model, sampled mid-low-phase.
    always @(negedge clk) begin
        #2;
        check("cmp_load_data", load_data, model_ld);
        check("cmp_access_err", 32'(access_err), 32'(done_flag & model_err));
        if (bus.req_valid) begin
            check("cmp_req_allowed", 32'(txn_active & ~no_req), 32'(1));
            check("cmp_req_addr", bus.req_addr, exp_addr);
            check("cmp_req_we", 32'(bus.req_we), 32'(exp_we));
            if (exp_we) begin
                check("cmp_req_wstrb", 32'(bus.req_wstrb), 32'(exp_wstrb));
                check("cmp_req_wdata", bus.req_wdata, exp_wdata);
            end
        end
    end

    // Drive one decoded access, act as memory, and check the retire cycle.
    task automatic run_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdata,
                          input int rdy_dly, input int rsp_dly, input logic err,
                          input int lit_stall, input logic [31:0] lit_addr,
                          input logic [3:0] lit_wstrb, input logic [31:0] lit_wdata,
                          input logic [31:0] lit_ld, input logic lit_trap);
        int   n_stall, n_req, n_wait;
        logic accepted, seen_req;
        n_stall = 0; n_req = 0; n_wait = 0; accepted = 1'b0; seen_req = 1'b0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; func3 = f3; addr = a; store_data = sd;
        exp_we = wr; exp_addr = {a[31:2], 2'b00};
        exp_wstrb = model_wstrb(f3, a); exp_wdata = model_wdata(f3, sd);
        no_req = lit_trap; txn_active = 1'b1;
        #1;
        check("issue_stall", 32'(stall), 32'(1));
        @(negedge clk);
        while (stall && n_stall < 40) begin
            n_stall++;
            bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_err = 1'b0;
            if (bus.req_valid) begin
                if (!seen_req) begin
                    seen_req = 1'b1;
                    check("req_addr_lit", bus.req_addr, lit_addr);
                    if (wr) begin
                        check("req_wstrb_lit", 32'(bus.req_wstrb), 32'(lit_wstrb));
                        check("req_wdata_lit", bus.req_wdata, lit_wdata);
                    end
                end
                if (n_req == rdy_dly) begin
                    bus.req_ready = 1'b1;
                    bus.rsp_err   = err & wr;
                    accepted      = 1'b1;
                end
                n_req++;
            end else if (accepted) begin
                n_wait++;
                if (n_wait == rsp_dly) begin
                    bus.rsp_valid = 1'b1; bus.rsp_rdata = rdata; bus.rsp_err = err;
                end
            end
            @(negedge clk);
        end
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_err = 1'b0;
        check("stall_cycles", 32'(n_stall), 32'(lit_stall));
        check("req_seen", 32'(seen_req), 32'(!lit_trap));
        check("retire_err", 32'(access_err), 32'(err | lit_trap));
        if (rd && !wr) check("load_lit", load_data, lit_ld);
        if (rd && !wr && !lit_trap) model_ld = model_load(f3, a, rdata);
        model_err = err | lit_trap;
        done_flag = 1'b1;
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b0;
        done_flag = 1'b0; txn_active = 1'b0; no_req = 1'b0;
        @(negedge clk);
        check("no_reissue", 32'(bus.req_valid), 32'(0));
        check("idle_after", 32'(state_dbg), 32'(IDLE));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; func3 = '0; addr = '0; store_data = '0;
        bus.req_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_rdata = '0; bus.rsp_err = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_stall", 32'(stall), 32'(0));
        check("rst_req_valid", 32'(bus.req_valid), 32'(0));
        check("rst_req_we", 32'(bus.req_we), 32'(0));
        check("rst_req_addr", bus.req_addr, 32'h0);
        check("rst_req_wstrb", 32'(bus.req_wstrb), 32'(0));
        check("rst_req_wdata", bus.req_wdata, 32'h0);
        check("rst_load_data", load_data, 32'h0);
        check("rst_state", 32'(state_dbg), 32'(IDLE));
        rst_n = 1'b1;

        // rd wr f3 addr sd rdata rdy rsp err | stall addr wstrb wdata ld trap
        run_op(0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0, 1, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 0);
        run_op(0, 1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 0, 0, 1, 32'h100, 4'h8, 32'hA5A5A5A5, 32'h0, 0);
        run_op(0, 1, 3'b001, 32'h102, 32'h0000BEEF, 32'h0, 0, 0, 0, 1, 32'h100, 4'hC, 32'hBEEFBEEF, 32'h0, 0);
        run_op(1, 0, 3'b000, 32'h201, 32'h0, 32'h123480FF, 0, 1, 0, 2, 32'h200, 4'h0, 32'h0, 32'hFFFFFF80, 0);
        run_op(1, 0, 3'b100, 32'h201, 32'h0, 32'h123480FF, 0, 1, 0, 2, 32'h200, 4'h0, 32'h0, 32'h00000080, 0);
        run_op(1, 0, 3'b101, 32'h202, 32'h0, 32'h123480FF, 0, 1, 0, 2, 32'h200, 4'h0, 32'h0, 32'h00001234, 0);
        run_op(1, 0, 3'b001, 32'h200, 32'h0, 32'h123480FF, 0, 1, 0, 2, 32'h200, 4'h0, 32'h0, 32'hFFFF80FF, 0);
        run_op(1, 0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 3, 2, 0, 6, 32'h400, 4'h0, 32'h0, 32'hCAFEF00D, 0);
        run_op(0, 1, 3'b010, 32'h104, 32'h11223344, 32'h0, 2, 0, 1, 3, 32'h104, 4'hF, 32'h11223344, 32'h0, 0);
        run_op(1, 0, 3'b010, 32'h108, 32'h0, 32'h55667788, 0, 1, 1, 2, 32'h108, 4'h0, 32'h0, 32'h55667788, 0);
        run_op(1, 1, 3'b000, 32'h101, 32'h0000007E, 32'h0, 0, 0, 0, 1, 32'h100, 4'h2, 32'h7E7E7E7E, 32'h0, 0);
        run_op(1, 0, 3'b111, 32'h20C, 32'h0, 32'h0BADBEEF, 0, 1, 0, 2, 32'h20C, 4'h0, 32'h0, 32'h0BADBEEF, 0);
        run_op(0, 1, 3'b100, 32'h108, 32'hA1B2C3D4, 32'h0, 0, 0, 0, 1, 32'h108, 4'hF, 32'hA1B2C3D4, 32'h0, 0);
        run_op(1, 0, 3'b010, 32'h301, 32'h0, 32'h89ABCDEF, 0, 1, 0, TRAP ? 0 : 2, 32'h300, 4'h0, 32'h0,
               TRAP ? 32'h0BADBEEF : 32'h89ABCDEF, TRAP);
        run_op(0, 1, 3'b001, 32'h101, 32'h00001357, 32'h0, 0, 0, 0, TRAP ? 0 : 1, 32'h100, 4'h3, 32'h13571357,
               32'h0, TRAP);

        // Reset while a load waits for its response; a late response must be ignored.
        @(negedge clk);
        mem_read = 1'b1; func3 = 3'b010; addr = 32'h500;
        exp_we = 1'b0; exp_addr = 32'h500; no_req = 1'b0; txn_active = 1'b1;
        @(negedge clk);
        check("rstw_req_valid", 32'(bus.req_valid), 32'(1));
        bus.req_ready = 1'b1;
        @(negedge clk);
        bus.req_ready = 1'b0;
        check("rstw_in_wait", 32'(state_dbg), 32'(WAIT_RSP));
        check("rstw_wait_stall", 32'(stall), 32'(1));
        #1;
        rst_n = 1'b0; model_ld = '0; txn_active = 1'b0;
        #1;
        check("rstw_req_drop", 32'(bus.req_valid), 32'(0));
        check("rstw_stall_drop", 32'(stall), 32'(0));
        check("rstw_load_clear", load_data, 32'h0);
        mem_read = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_valid = 1'b1; bus.rsp_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        bus.rsp_valid = 1'b0;
        @(negedge clk);
        check("late_rsp_load", load_data, 32'h0);
        check("late_rsp_state", 32'(state_dbg), 32'(IDLE));
        check("late_rsp_stall", 32'(stall), 32'(0));

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
